// File: rtl/selladora_pkg.sv
// Shared definitions for the sock-line sealing station: state encoding,
// default size acceptance mask and a small helper for sizing the dwell counter.
package selladora_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FEED   = 3'd1;
    localparam logic [2:0] ST_SEAL   = 3'd2;
    localparam logic [2:0] ST_EJECT  = 3'd3;
    localparam logic [2:0] ST_REJECT = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        FEED   = ST_FEED,
        SEAL   = ST_SEAL,
        EJECT  = ST_EJECT,
        REJECT = ST_REJECT,
        FAULT  = ST_FAULT
    } state_t;

    // Sizes 1, 4 and 7 are sealed at this station by default
    localparam logic [7:0] DEFAULT_ACCEPT_MASK = 8'b1001_0010;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Shared dwell counter: counts up from zero after each clear and flags when
// the programmed terminal count is reached.
module dwell_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] tc,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == tc);

endmodule

// File: rtl/selladora_param.sv
// Parametrised sealing-station controller: feed, seal, eject accepted socks,
// divert rejected sizes, latch feed jams and count accepted socks per batch.
module selladora_param
    import selladora_pkg::*;
#(
    parameter int                   SIZE_W        = 3,
    parameter logic [2**SIZE_W-1:0] ACCEPT_MASK   = DEFAULT_ACCEPT_MASK,
    parameter int                   SEAL_CYCLES   = 4,
    parameter int                   EJECT_CYCLES  = 2,
    parameter int                   REJECT_CYCLES = 2,
    parameter int                   JAM_TIMEOUT   = 16,
    parameter int                   BATCH         = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sock_valid,
    input  logic [SIZE_W-1:0]        size,
    input  logic                     at_sealer,
    input  logic                     fault_clear,
    output logic                     feed_en,
    output logic                     seal_en,
    output logic                     eject_en,
    output logic                     reject_en,
    output logic                     busy,
    output logic                     fault,
    output logic                     batch_done,
    output logic [$clog2(BATCH)-1:0] batch_count
);

    localparam int MAX_CYC = max4(SEAL_CYCLES, EJECT_CYCLES, REJECT_CYCLES, JAM_TIMEOUT);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int BC_W    = $clog2(BATCH);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  dwell_tc;
    logic              dwell_clear;
    logic              dwell_done;
    logic              eject_exit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The terminal count is chosen per state so one counter serves every dwell
    always_comb begin
        next_state = state;
        dwell_tc   = '0;
        case (state)
            IDLE: begin
                if (sock_valid) begin
                    next_state = ACCEPT_MASK[size] ? FEED : REJECT;
                end
            end
            FEED: begin
                dwell_tc = CNT_W'(JAM_TIMEOUT - 1);
                if (at_sealer) begin
                    next_state = SEAL;
                end else if (dwell_done) begin
                    next_state = FAULT;
                end
            end
            SEAL: begin
                dwell_tc = CNT_W'(SEAL_CYCLES - 1);
                if (dwell_done) next_state = EJECT;
            end
            EJECT: begin
                dwell_tc = CNT_W'(EJECT_CYCLES - 1);
                if (dwell_done) next_state = IDLE;
            end
            REJECT: begin
                dwell_tc = CNT_W'(REJECT_CYCLES - 1);
                if (dwell_done) next_state = IDLE;
            end
            FAULT: begin
                if (fault_clear) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign dwell_clear = (next_state != state) || (state == IDLE) || (state == FAULT);

    dwell_timer #(
        .W (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clear (dwell_clear),
        .tc    (dwell_tc),
        .done  (dwell_done)
    );

    assign feed_en   = (state == FEED);
    assign seal_en   = (state == SEAL);
    assign eject_en  = (state == EJECT);
    assign reject_en = (state == REJECT);
    assign busy      = (state != IDLE);
    assign fault     = (state == FAULT);

    assign eject_exit = (state == EJECT) && dwell_done;

    // Batch counter advances only when an accepted sock leaves the eject plate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            batch_count <= '0;
            batch_done  <= 1'b0;
        end else begin
            batch_done <= 1'b0;
            if (eject_exit) begin
                if (batch_count == BC_W'(BATCH - 1)) begin
                    batch_count <= '0;
                    batch_done  <= 1'b1;
                end else begin
                    batch_count <= batch_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/selladora_param.md
# selladora_param

Parametrised sealing-station controller for the sock line, the generalised successor of the fixed three-bit low-end sealer FSM. It accepts a sock size code and presence strobe, rejects sizes not enabled in a mask, and runs feed → seal → eject for accepted socks. Dwell times come from internal counters instead of an external timer input. It adds a feed-jam timeout with a latched fault, and a batch counter that pulses when a bag-sized batch is complete.

## Interface
Parameters:
- SIZE_W, 3, width of the size code
- ACCEPT_MASK, 8'b1001_0010, 2**SIZE_W bits; bit i=1 means size i is sealed here
- SEAL_CYCLES, 4, cycles seal_en is held (≥1)
- EJECT_CYCLES, 2, cycles eject_en is held (≥1)
- REJECT_CYCLES, 2, cycles reject_en is held (≥1)
- JAM_TIMEOUT, 16, max FEED cycles before fault (≥1)
- BATCH, 12, accepted socks per batch (≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- sock_valid  in  1  sock present at station entry
- size  in  SIZE_W  size code, qualified by sock_valid
- at_sealer  in  1  sock positioned under sealing head
- fault_clear  in  1  operator acknowledge
- feed_en  out  1  conveyor forward
- seal_en  out  1  sealing head active
- eject_en  out  1  eject plate active
- reject_en  out  1  divert gate active
- busy  out  1  state ≠ IDLE
- fault  out  1  jam fault latched
- batch_done  out  1  one-cycle pulse at batch completion
- batch_count  out  $clog2(BATCH)  accepted socks in current batch

## Operation
- States: IDLE, FEED, SEAL, EJECT, REJECT, FAULT. Moore outputs are decoded from the state register only.
- IDLE: sock_valid && ACCEPT_MASK[size] → FEED. sock_valid && !ACCEPT_MASK[size] → REJECT. Otherwise stay.
- FEED: feed_en=1. at_sealer → SEAL. If JAM_TIMEOUT cycles elapse in FEED without at_sealer → FAULT. at_sealer on the final timeout cycle wins: go to SEAL.
- SEAL: seal_en=1 for exactly SEAL_CYCLES cycles, then → EJECT.
- EJECT: eject_en=1 for EJECT_CYCLES cycles. On exit go to IDLE and increment batch_count.
  - If batch_count was BATCH-1, it wraps to 0 and batch_done pulses for one cycle on the same edge.
- REJECT: reject_en=1 for REJECT_CYCLES cycles, then → IDLE. batch_count is unchanged.
- FAULT: all actuators 0, fault=1, busy=1. fault_clear → IDLE. batch_count is retained.
- sock_valid outside IDLE is ignored; no queuing.
- A single shared dwell counter is cleared on every state entry.
- Reset (any time, including mid-seal): state IDLE, counter 0, batch_count 0. All outputs 0.

## Timing
- sock_valid sampled high at edge k → feed_en (or reject_en) high from edge k to the next transition; 1-cycle latency.
- at_sealer sampled at edge k → seal_en high from edge k for SEAL_CYCLES cycles.
- Accepted sock, minimum IDLE-to-IDLE time: 1 + SEAL_CYCLES + EJECT_CYCLES cycles, plus feed time.
- batch_done is asserted in the cycle after the final EJECT cycle, coincident with the IDLE return.
- fault rises on the edge after the JAM_TIMEOUT-th FEED cycle.
- Exactly one of feed_en/seal_en/eject_en/reject_en is high in any cycle, or none.

## Structure
- Package selladora_pkg holds:
  - the state encoding (3-bit localparams: IDLE=0, FEED=1, SEAL=2, EJECT=3, REJECT=4, FAULT=5)
  - the default ACCEPT_MASK
- Sub-module dwell_timer holds the counter, with clear and a programmable terminal count. Its done output is used for SEAL, EJECT, REJECT and the jam timeout. Width is $clog2 of the largest cycle parameter, plus 1.
- Top level holds the state register, next-state logic, output decode and batch counter.

## Test plan
- size=3'b100, sock_valid 1 cycle, at_sealer 3 cycles later:
  - feed_en high 3 cycles, seal_en 4, eject_en 2
  - batch_count 0→1, busy low afterwards
- size=3'b010, sock_valid: reject_en high 2 cycles, no feed/seal, batch_count unchanged.
- Accepted sock with at_sealer never asserted:
  - feed_en high 16 cycles, then fault=1 with all actuators 0
  - fault_clear → IDLE with fault=0, batch_count retained
- 12 accepted socks back-to-back: batch_done pulses once, after the 12th eject; batch_count reads 0.
- reset asserted mid-SEAL: all outputs 0 immediately, batch_count 0. Next accepted sock runs the full sequence.
- sock_valid toggled during SEAL/EJECT: ignored; exactly one seal per accepted sock.
